// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one two-stage pipelined ALU between two requesters.
// Operands issue one edge ahead of opcode/carry; a tag pipeline routes each result back.
module alu_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_d,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_abus,
  output logic [WIDTH-1:0] alu_bbus,
  output logic [2:0]       alu_S,
  output logic             alu_Cin,
  input  logic [WIDTH-1:0] alu_dbus
);

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Illegal ops still occupy a slot but drive a harmless select into the ALU.
  function automatic logic [2:0] alu_sel(input logic [2:0] op, input logic ill);
    return ill ? 3'b000 : op;
  endfunction

  logic       last_gnt;
  logic       gnt0, gnt1;
  logic       xfer, xid;
  logic [2:0] sel_op;
  logic       sel_cin;

  logic       vld_p0, id_p0, ill_p0;
  logic [2:0] op_p0;
  logic       cin_p0;
  logic       vld_p1, id_p1, ill_p1;
  logic       vld_p2, id_p2, ill_p2;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!hold) begin
      if (req0_valid && (!req1_valid || last_gnt)) gnt0 = 1'b1;
      else if (req1_valid)                         gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = (req0_valid && gnt0) || (req1_valid && gnt1);
  assign xid        = gnt1;
  assign sel_op     = xid ? req1_op  : req0_op;
  assign sel_cin    = xid ? req1_cin : req0_cin;

  // Stage p0: accept edge, operands to the ALU, tag enters the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      alu_abus <= '0;
      alu_bbus <= '0;
      vld_p0   <= 1'b0;
      id_p0    <= 1'b0;
      ill_p0   <= 1'b0;
    end else begin
      vld_p0 <= xfer;
      if (xfer) begin
        last_gnt <= xid;
        alu_abus <= xid ? req1_a : req0_a;
        alu_bbus <= xid ? req1_b : req0_b;
        id_p0    <= xid;
        ill_p0   <= (sel_op == OP_ILLEGAL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      op_p0  <= sel_op;
      cin_p0 <= sel_cin;
    end
  end

  // Stage p1: opcode/carry follow their operands by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_S   <= 3'b000;
      alu_Cin <= 1'b0;
      vld_p1  <= 1'b0;
      id_p1   <= 1'b0;
      ill_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      id_p1  <= id_p0;
      ill_p1 <= ill_p0;
      if (vld_p0) begin
        alu_S   <= alu_sel(op_p0, ill_p0);
        alu_Cin <= cin_p0;
      end
    end
  end

  // Stage p2: ALU computing; tag waits for dbus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      id_p2  <= 1'b0;
      ill_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      ill_p2 <= ill_p1;
    end
  end

  // Response stage: capture dbus and pulse the owning requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_d      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp0_valid <= vld_p2 && !id_p2;
      rsp1_valid <= vld_p2 && id_p2;
      rsp_err    <= vld_p2 && ill_p2;
      if (vld_p2) rsp_d <= ill_p2 ? '0 : alu_dbus;
    end
  end

  assign busy = vld_p0 || vld_p1 || vld_p2;

endmodule
